// File: rtl/ctrl_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, FSM states and
// instruction field positions. The opcode encoding is shared with the ALU.
package ctrl_pkg;

  localparam int INSTR_W = 12;
  localparam int OPC_MSB = 11;
  localparam int OPC_LSB = 8;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;
  localparam int IDX_LSB = 0;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_NOT  = 4'd5,
    OP_LD   = 4'd6,
    OP_ST   = 4'd7,
    OP_INC  = 4'd8,
    OP_DEC  = 4'd9,
    OP_SHL  = 4'd10,
    OP_SHR  = 4'd11,
    OP_LDI  = 4'd12,
    OP_JMP  = 4'd13,
    OP_JZ   = 4'd14,
    OP_HALT = 4'd15
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALTED
  } state_e;

  function automatic logic is_alu_op(opcode_e op);
    return op < OP_LDI;
  endfunction

  function automatic logic sets_carry(opcode_e op);
    return op inside {OP_ADD, OP_SUB, OP_INC,
                      OP_DEC, OP_SHL, OP_SHR};
  endfunction

endpackage

// File: rtl/seq_regfile.sv
// General register file R0..R(NREG-1) for the ALU sequencer.
// Ports: clk/rst, we/waddr/wdata sync write, raddr/rdata comb read.
module seq_regfile #(
  parameter int SIZE = 8,
  parameter int NREG = 4,
  localparam int IDX_W = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [SIZE-1:0]  wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [SIZE-1:0]  rdata
);

  logic [SIZE-1:0] mem_q [NREG];
  logic [SIZE-1:0] mem_d [NREG];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/alu_seq_ctrl.sv
// Instruction sequencer feeding the ALU: fetch, decode, execute, writeback.
// Ports: clk/rst, start/halted, imem_* fetch, alu_* drive/capture, acc/flags.
module alu_seq_ctrl
  import ctrl_pkg::*;
#(
  parameter int SIZE = 8,
  parameter int PC_W = 8,
  parameter int NREG = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               halted,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               alu_ce,
  output logic [3:0]         alu_op,
  output logic [SIZE-1:0]    alu_left,
  output logic [SIZE-1:0]    alu_right,
  output logic               alu_carry_in,
  input  logic               alu_carry_out,
  input  logic [SIZE-1:0]    alu_result,
  output logic [SIZE-1:0]    acc_out,
  output logic               flag_c,
  output logic               flag_z
);

  localparam int IDX_W = $clog2(NREG);
  localparam int IMM_W = IMM_MSB - IMM_LSB + 1;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [SIZE-1:0]    acc_q, acc_d;
  logic [SIZE-1:0]    opnd_q, opnd_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               c_q, c_d;
  logic               z_q, z_d;

  opcode_e          op;
  logic [IMM_W-1:0] imm;
  logic [IDX_W-1:0] idx;
  logic             exec_alu;
  logic             rf_we;
  logic [SIZE-1:0]  rf_rdata;

  assign op  = opcode_e'(ir_q[OPC_MSB:OPC_LSB]);
  assign imm = ir_q[IMM_MSB:IMM_LSB];
  assign idx = ir_q[IDX_LSB +: IDX_W];

  assign exec_alu = (state_q == S_EXEC) && is_alu_op(op);

  seq_regfile #(
    .SIZE (SIZE),
    .NREG (NREG)
  ) u_rf (
    .clk   (clk),
    .rst   (rst),
    .we    (rf_we),
    .waddr (idx),
    .wdata (alu_result),
    .raddr (idx),
    .rdata (rf_rdata)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    ir_d    = ir_q;
    c_d     = c_q;
    z_d     = z_q;
    rf_we   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_valid) begin
          ir_d    = imem_data;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        opnd_d  = rf_rdata;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        pc_d    = pc_q + PC_W'(1);
        if (is_alu_op(op)) begin
          if (op == OP_ST) begin
            rf_we = 1'b1;
          end else begin
            acc_d = alu_result;
            z_d   = (alu_result == '0);
          end
          if (sets_carry(op)) c_d = alu_carry_out;
        end else begin
          case (op)
            OP_LDI: begin
              acc_d = SIZE'(imm);
              z_d   = (SIZE'(imm) == '0);
            end
            OP_JMP: pc_d = PC_W'(imm);
            OP_JZ: begin
              if (z_q) pc_d = PC_W'(imm);
            end
            OP_HALT: begin
              pc_d    = pc_q;
              state_d = S_HALTED;
            end
            default: ;
          endcase
        end
      end
      S_HALTED: begin
        if (start) begin
          pc_d    = '0;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      ir_q    <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      ir_q    <= ir_d;
      c_q     <= c_d;
      z_q     <= z_d;
    end
  end

  always_comb begin
    alu_ce    = exec_alu;
    alu_op    = exec_alu ? ir_q[OPC_MSB:OPC_LSB] : 4'd0;
    alu_left  = exec_alu ? acc_q : '0;
    alu_right = exec_alu ? opnd_q : '0;
  end

  assign alu_carry_in = 1'b0;
  assign imem_req     = (state_q == S_FETCH);
  assign imem_addr    = pc_q;
  assign halted       = (state_q == S_HALTED);
  assign acc_out      = acc_q;
  assign flag_c       = c_q;
  assign flag_z       = z_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a behavioural ALU and program memory.
// Memory latency is programmable via wait_n.
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        halted;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_valid;
  logic [11:0] imem_data;
  logic        alu_ce;
  logic [3:0]  alu_op;
  logic [7:0]  alu_left;
  logic [7:0]  alu_right;
  logic        alu_carry_in;
  logic        alu_carry_out;
  logic [7:0]  alu_result;
  logic [7:0]  acc_out;
  logic        flag_c;
  logic        flag_z;

  int n_vec = 0;
  int n_err = 0;
  int wait_n = 0;
  int wcnt = 0;
  int ce_cnt = 0;
  int ce0;
  int n;

  logic [11:0] imem [256];

  always #5 clk = ~clk;

  alu_seq_ctrl #(.SIZE(8), .PC_W(8), .NREG(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .halted        (halted),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_valid    (imem_valid),
    .imem_data     (imem_data),
    .alu_ce        (alu_ce),
    .alu_op        (alu_op),
    .alu_left      (alu_left),
    .alu_right     (alu_right),
    .alu_carry_in  (alu_carry_in),
    .alu_carry_out (alu_carry_out),
    .alu_result    (alu_result),
    .acc_out       (acc_out),
    .flag_c        (flag_c),
    .flag_z        (flag_z)
  );

  assign imem_data  = imem[imem_addr];
  assign imem_valid = imem_req && (wcnt >= wait_n);

  always @(posedge clk) begin
    if (imem_req && !imem_valid) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  always @(negedge clk) begin
    if (alu_ce) ce_cnt <= ce_cnt + 1;
  end

  always_comb begin
    logic [8:0] t;
    t = 9'd0;
    unique case (alu_op)
      4'd0:  t = {1'b0, alu_left} + {1'b0, alu_right};
      4'd1:  t = {1'b0, alu_left} - {1'b0, alu_right};
      4'd2:  t = {1'b0, alu_left & alu_right};
      4'd3:  t = {1'b0, alu_left | alu_right};
      4'd4:  t = {1'b0, alu_left ^ alu_right};
      4'd5:  t = {1'b0, ~alu_left};
      4'd6:  t = {1'b0, alu_right};
      4'd7:  t = {1'b0, alu_left};
      4'd8:  t = {1'b0, alu_left} + 9'd1;
      4'd9:  t = {1'b0, alu_left} - 9'd1;
      4'd10: t = {alu_left, 1'b0};
      4'd11: t = {alu_left[0], 1'b0, alu_left[7:1]};
      default: t = 9'd0;
    endcase
    alu_result    = t[7:0];
    alu_carry_out = t[8];
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) imem[i] = 12'hF00;
  endtask

  task automatic load_prog1();
    clear_mem();
    imem[0] = 12'hC05;
    imem[1] = 12'h701;
    imem[2] = 12'hC03;
    imem[3] = 12'h001;
    imem[4] = 12'hF00;
  endtask

  task automatic do_reset();
    start = 1'b0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_halt(input int n0, output int nout);
    nout = n0;
    while (!halted && nout < 200) begin
      tick(1);
      nout++;
    end
  endtask

  initial begin
    load_prog1();
    #1;
    chk("rst_req", imem_req, 1'b0);
    chk("rst_ce", alu_ce, 1'b0);
    chk("rst_acc", acc_out, 8'h00);
    chk("rst_flags", {flag_c, flag_z, halted}, 3'b000);
    chk("rst_addr", imem_addr, 8'h00);
    do_reset();
    chk("idle_req", imem_req, 1'b0);

    ce0 = ce_cnt;
    pulse_start();
    tick(3);
    chk("t1_fetch_acc", acc_out, 8'h05);
    chk("t1_fetch_left", alu_left, 8'h00);
    chk("t1_fetch_ce", alu_ce, 1'b0);
    tick(2);
    chk("t1_st_ce", alu_ce, 1'b1);
    chk("t1_st_op", alu_op, 4'd7);
    chk("t1_st_opnd", {alu_left, alu_right}, 16'h0500);
    wait_halt(5, n);
    chk("t1_lat", n, 15);
    chk("t1_acc", acc_out, 8'h08);
    chk("t1_cz", {flag_c, flag_z}, 2'b00);
    chk("t1_ce_cnt", ce_cnt - ce0, 2);

    clear_mem();
    imem[0] = 12'h601;
    pulse_start();
    chk("t2_refetch", {imem_req, imem_addr}, 9'h100);
    wait_halt(0, n);
    chk("t2_r1_kept", acc_out, 8'h05);

    do_reset();
    clear_mem();
    imem[0] = 12'hCFF;
    imem[1] = 12'h702;
    imem[2] = 12'hC01;
    imem[3] = 12'h002;
    imem[4] = 12'hE20;
    pulse_start();
    wait_halt(0, n);
    chk("t3_acc", acc_out, 8'h00);
    chk("t3_cz", {flag_c, flag_z}, 2'b11);
    chk("t3_jz_taken", imem_addr, 8'h20);

    do_reset();
    clear_mem();
    imem[0] = 12'hC01;
    imem[1] = 12'hE20;
    pulse_start();
    wait_halt(0, n);
    chk("t3_jz_fall", imem_addr, 8'h02);

    do_reset();
    load_prog1();
    wait_n = 3;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      chk("t4_hold", {imem_req, alu_ce, imem_addr},
          10'h200);
      tick(1);
    end
    chk("t4_released", imem_req, 1'b0);
    wait_halt(4, n);
    chk("t4_lat", n, 30);
    chk("t4_acc", acc_out, 8'h08);
    wait_n = 0;

    do_reset();
    load_prog1();
    pulse_start();
    tick(11);
    chk("t5_exec_add", {alu_ce, alu_op}, 5'h10);
    chk("t5_add_opnd", {alu_left, alu_right}, 16'h0305);
    rst = 1'b1;
    #1;
    chk("t5_async", {imem_req, alu_ce}, 2'b00);
    chk("t5_acc0", acc_out, 8'h00);
    tick(1);
    rst = 1'b0;
    tick(1);
    chk("t5_idle", {imem_req, halted, imem_addr}, 10'h000);
    chk("t5_no_wb", acc_out, 8'h00);

    do_reset();
    clear_mem();
    imem[0]   = 12'hDFF;
    imem[255] = 12'hC11;
    pulse_start();
    tick(3);
    chk("t6_jmp", {imem_req, imem_addr}, 9'h1FF);
    tick(3);
    chk("t6_wrap", {imem_req, imem_addr}, 9'h100);
    chk("t6_acc", acc_out, 8'h11);

    do_reset();
    load_prog1();
    pulse_start();
    tick(2);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_halt(3, n);
    chk("t7_lat", n, 15);
    chk("t7_acc", acc_out, 8'h08);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Instruction sequencer directly upstream of the ALU. Fetches 12-bit instructions from program memory and decodes them.
- Drives the ALU's CE, opcode, operands and carry_in. Captures the ALU result and carry into an accumulator, a 4x8 register file and C/Z flags.
- Also executes immediate-load, jump, branch-on-zero and halt, none of which use the ALU.

Parameters:
- SIZE, 8, datapath width; must match the ALU SIZE.
- PC_W, 8, program counter and instruction-memory address width.
- NREG, 4, general registers R0..R3.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse. Honoured only in IDLE or HALTED.
- halted  out  1  high while in HALTED.
- imem_req  out  1  fetch request.
- imem_addr  out  PC_W  fetch address (= PC).
- imem_valid  in  1  instruction data valid.
- imem_data  in  12  instruction: [11:8] opcode, [7:0] immediate, [1:0] register index.
- alu_ce  out  1  ALU enable.
- alu_op  out  4  ALU opcode.
- alu_left  out  SIZE  left operand (ACC).
- alu_right  out  SIZE  right operand (R[idx]).
- alu_carry_in  out  1  tied 0.
- alu_carry_out  in  1  ALU carry.
- alu_result  in  SIZE  ALU op_out.
- acc_out  out  SIZE  accumulator.
- flag_c  out  1  carry flag.
- flag_z  out  1  zero flag.

Behaviour:
- Reset:
  - Asynchronous: state=IDLE, PC=0, ACC=0, R0..R3=0, C=0, Z=0, IR=0.
  - All outputs 0 immediately, including imem_req and alu_ce. Reset mid-fetch or mid-EXEC aborts with no writeback.
- FSM states: IDLE, FETCH, DECODE, EXEC, HALTED.
  - IDLE: start -> FETCH.
  - FETCH: imem_req=1 and imem_addr=PC, held stable until imem_valid. On imem_valid, latch IR<=imem_data and go to DECODE.
  - imem_valid is ignored outside FETCH.
  - DECODE: latch operand R[IR[1:0]] into a right-operand register -> EXEC.
  - EXEC: one cycle. Writeback and PC update occur on the closing edge, then -> FETCH (HALTED for HALT).
  - HALTED: start -> PC=0, FETCH. Registers, ACC and flags are retained.
- Latency: 3 cycles per instruction with zero-wait memory (imem_valid in the first FETCH cycle). Each wait cycle adds 1.
- Opcodes 0-11 are ALU ops: ADD, SUB, AND, OR, XOR, NOT, LD, ST, INC, DEC, SHL, SHR.
  - alu_ce=1 only in EXEC, with alu_op=IR[11:8], alu_left=ACC and alu_right=latched R[idx].
  - alu_op, alu_left and alu_right are 0 outside EXEC.
- ALU contract: OP_LD passes alu_right and OP_ST passes alu_left.
- Writeback:
  - ST: R[idx]<=alu_result; ACC and flags unchanged.
  - All other ALU ops: ACC<=alu_result and Z<=(alu_result==0).
  - C<=alu_carry_out for ADD, SUB, INC, DEC, SHL, SHR; C unchanged otherwise.
- Non-ALU opcodes (alu_ce stays 0):
  - 12 LDI: ACC<=imm, Z updated.
  - 13 JMP: PC<=imm.
  - 14 JZ: PC<=imm if Z, else PC+1.
  - 15 HALT: PC frozen.
- PC: incremented modulo 2^PC_W (0xFF -> 0x00) for every non-jump instruction.
- start: ignored in FETCH, DECODE and EXEC.

Decomposition:
- Package ctrl_pkg holds:
  - the 4-bit opcode enum, shared with the ALU (OP_ADD..OP_SHR, OP_LDI, OP_JMP, OP_JZ, OP_HALT);
  - the FSM state enum;
  - the field-position constants for the instruction word.
- Sub-module seq_regfile: NREG x SIZE, one combinational read port, one synchronous write port, async-reset to 0.

Test Plan:
- Zero-wait program {LDI 0x05; ST R1; LDI 0x03; ADD R1; HALT} then start -> ACC=0x08, C=0, Z=0, halted=1. alu_ce pulses exactly twice (ST, ADD). halted rises 15 cycles after start.
- {LDI 0xFF; ST R2; LDI 0x01; ADD R2} -> ACC=0x00, C=1, Z=1. Follow with JZ 0x20 -> next imem_addr=0x20. With Z=0 the same JZ -> imem_addr=PC+1.
- imem_valid delayed 3 cycles on every fetch -> imem_req held with imem_addr stable for 4 cycles; alu_ce=0 throughout FETCH. Final ACC identical to the zero-wait run.
- rst asserted during the EXEC of ADD R1 -> imem_req and alu_ce drop in the same cycle. ACC=0, PC=0, state IDLE; no writeback occurs.
- JMP 0xFF, then a LDI 0x11 placed at 0xFF -> next fetch address wraps to 0x00.
- start pulsed during EXEC -> no effect. start in HALTED -> refetch from 0x00 with R1 retained.
